program_loader: RTL

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/loader_pkg.sv | 17 +
 rtl/byte_assembler.sv | 34 +++
 rtl/program_loader.sv | 108 ++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared loader types: FSM state encoding and word geometry.
// Imported by program_loader and byte_assembler.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WRITE,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int BCNT_W = $clog2(BYTES_PER_WORD);
  localparam int WORD_W = 8 * BYTES_PER_WORD;

endpackage

// File: rtl/byte_assembler.sv
// Big-endian byte-to-word assembler with byte counter.
// Ports: clk, reset (sync, low), clear, shift_en, byte_in -> word_next, word_ready.
module byte_assembler
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              shift_en,
  input  logic [7:0]        byte_in,
  output logic [WORD_W-1:0] word_next,
  output logic              word_ready
);

  // Only the first three bytes are stored; the last one is
  // taken straight from byte_in when the word completes.
  logic [WORD_W-9:0] sr;
  logic [BCNT_W-1:0] cnt;

  assign word_next  = {sr, byte_in};
  assign word_ready = shift_en &&
                      (cnt == BCNT_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      sr  <= '0;
      cnt <= '0;
    end else if (shift_en) begin
      sr  <= word_next[WORD_W-9:0];
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Streams bytes into words and writes them to instruction memory.
// Ports: clk, reset, Start/Length, byte handshake, write port, Busy/Done/Overflow.
module program_loader
  import loader_pkg::*;
#(
  parameter int MEMORY_DEPTH = 32,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            Start,
  input  logic [$clog2(MEMORY_DEPTH):0]   Length,
  input  logic                            ByteValid,
  input  logic [7:0]                      ByteData,
  output logic                            ByteReady,
  output logic                            WriteEnable,
  output logic [DATA_WIDTH-1:0]           WriteAddress,
  output logic [DATA_WIDTH-1:0]           WriteData,
  output logic                            Busy,
  output logic                            Done,
  output logic                            Overflow
);

  localparam int LW = $clog2(MEMORY_DEPTH) + 1;

  state_t          state;
  state_t          nstate;
  logic [LW-1:0]   len_q;
  logic [LW-1:0]   idx;
  logic [LW-1:0]   idx_inc;
  logic            start_ok;
  logic            hs;
  logic [WORD_W-1:0] word_next;
  logic            word_ready;

  assign idx_inc  = idx + 1'b1;
  assign hs       = ByteValid && ByteReady;
  assign start_ok = Start && (state == ST_IDLE ||
                              state == ST_DONE ||
                              state == ST_ERROR);

  byte_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (start_ok),
    .shift_en   (hs),
    .byte_in    (ByteData),
    .word_next  (word_next),
    .word_ready (word_ready)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (Start) begin
          if (Length == '0)
            nstate = ST_DONE;
          else if (int'(Length) > MEMORY_DEPTH)
            nstate = ST_ERROR;
          else
            nstate = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (word_ready) nstate = ST_WRITE;
      end
      ST_WRITE: begin
        if (idx_inc == len_q) nstate = ST_DONE;
        else                  nstate = ST_LOAD;
      end
      default: nstate = ST_IDLE;
    endcase
  end

  // Write port is latched on entry to WRITE so it holds
  // steady whenever the strobe is low.
  always_ff @(posedge clk) begin
    if (!reset) begin
      len_q        <= '0;
      idx          <= '0;
      WriteData    <= '0;
      WriteAddress <= '0;
    end else begin
      if (start_ok) begin
        len_q <= Length;
        idx   <= '0;
      end
      if (state == ST_LOAD && word_ready) begin
        WriteData    <= DATA_WIDTH'(word_next);
        WriteAddress <= DATA_WIDTH'(idx) << 2;
      end
      if (state == ST_WRITE) idx <= idx_inc;
    end
  end

  assign ByteReady   = (state == ST_LOAD);
  assign WriteEnable = (state == ST_WRITE);
  assign Busy        = (state == ST_LOAD) || (state == ST_WRITE);
  assign Done        = (state == ST_DONE);
  assign Overflow    = (state == ST_ERROR);

endmodule
